// File: rtl/imem_port.sv
`default_nettype none
// ============================================================================
// Module : imem_port
// Brief  : Fetch-path instruction memory responder with wait states and load port
// Rev    : 1.0
// ============================================================================
module imem_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1,
  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [31:0]   i_req_addr,
  output logic          o_resp_valid,
  input  logic          i_resp_ready,
  output logic [31:0]   o_resp_inst,
  output logic          o_resp_err,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_idx,
  input  logic [31:0]   i_ld_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0]  c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [31:0] c_DEPTH     = 32'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_err;
  logic [31:0]   r_resp_inst;
  logic          r_resp_err;
  logic          r_resp_valid;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_offset;
  logic [31:0]   w_word;
  logic          w_err;
  logic          w_accept;
  logic          w_ld_wr;

  // Unsigned wrap of the subtraction is harmless: below-base addresses are flagged separately.
  assign w_offset = i_req_addr - BASE_ADDR;
  assign w_word   = w_offset >> 2;
  assign w_err    = (i_req_addr[1:0] != 2'b00) ||
                    (i_req_addr < BASE_ADDR)   ||
                    (w_word >= c_DEPTH);

  assign o_req_ready = (r_state == S_IDLE) && !i_ld_en;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_ld_wr     = (r_state == S_IDLE) && i_ld_en;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_inst  = r_resp_inst;
  assign o_resp_err   = r_resp_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_READ;
      S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_READ;
      S_READ: w_state_nxt = S_RESP;
      S_RESP: if (i_resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_resp_inst  <= 32'h0;
      r_resp_err   <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx <= w_word[AW-1:0];
            r_err <= w_err;
            r_cnt <= c_WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_READ: begin
          // Faulting fetches return a NOP and leave the array untouched.
          if (r_err) begin
            r_resp_inst <= 32'h0;
          end else begin
            r_resp_inst <= r_mem[r_idx];
          end
          r_resp_err   <= r_err;
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (i_resp_ready) r_resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_ld_wr) begin
      r_mem[i_ld_idx] <= i_ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_port.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_port
// Brief  : Self-checking bench for imem_port against a behavioural memory model
// Rev    : 1.0
// ============================================================================
module tb_imem_port;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam int          W     = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, resp_valid, resp_ready, resp_err, ld_en;
  logic [31:0]   req_addr, resp_inst, ld_data;
  logic [AW-1:0] ld_idx;

  logic          b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err, b_ld_en;
  logic [31:0]   b_req_addr, b_resp_inst, b_ld_data;
  logic [AW-1:0] b_ld_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_ok  [DEPTH];
  int          loaded_q [$];

  always #5 clk = ~clk;

  imem_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_inst(resp_inst), .o_resp_err(resp_err),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data)
  );

  imem_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_addr(b_req_addr),
    .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
    .o_resp_inst(b_resp_inst), .o_resp_err(b_resp_err),
    .i_ld_en(b_ld_en), .i_ld_idx(b_ld_idx), .i_ld_data(b_ld_data)
  );

  // Reference: byte address -> (fault, word) using signed arithmetic on the offset.
  function automatic void model(input logic [31:0] a, output logic e, output logic [31:0] inst);
    longint off;
    off  = longint'({32'd0, a}) - longint'({32'd0, BASE});
    e    = ((a % 4) != 0) || (off < 0) || ((off / 4) >= DEPTH);
    inst = e ? 32'h0 : ref_mem[int'(off / 4)];
  endfunction

  task automatic load1(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx[AW-1:0]; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[idx] = d;
    if (!ref_ok[idx]) loaded_q.push_back(idx);
    ref_ok[idx] = 1'b1;
  endtask

  // Drives one request; returns at the falling edge where the response is first seen.
  // lat counts rising edges from acceptance to resp_valid.
  task automatic do_fetch(input logic [31:0] a, output logic [31:0] inst, output logic e,
                          output int lat, output bit tmo);
    int n;
    tmo = 1'b0; lat = 0; inst = 32'h0; e = 1'b0; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin tmo = 1'b1; req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!resp_valid) begin tmo = 1'b1; return; end
    inst = resp_inst; e = resp_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    n_vec++; if (resp_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 00000000", resp_inst); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", resp_err); end
    n_vec++; if (b_resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid0: got %b want 0", b_resp_valid); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_vec++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready0: got %b want 1", b_req_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] inst, exp_inst; logic e, exp_e; int lat; bit tmo;
    logic [31:0] addrs [2];
    load1(0, 32'h2008_000A);
    load1(1, 32'h2009_0005);
    addrs[0] = BASE; addrs[1] = BASE + 32'd4;
    for (int i = 0; i < 2; i++) begin
      resp_ready = 1'b1;
      do_fetch(addrs[i], inst, e, lat, tmo);
      model(addrs[i], exp_e, exp_inst);
      n_vec++; if (tmo) begin n_err++; $display("FAIL basic_timeout: got timeout want response"); end
      n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL basic_lat: got %0d want %0d", lat, W + 1); end
      n_vec++; if (inst !== exp_inst) begin n_err++; $display("FAIL basic_inst: got %h want %h", inst, exp_inst); end
      n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL basic_err: got %b want %b", e, exp_e); end
      @(negedge clk);
    end
  endtask

  task automatic test_errors();
    logic [31:0] inst; logic e; int lat; bit tmo;
    logic [31:0] addrs [4];
    logic [31:0] exp_inst; logic exp_e;
    load1(DEPTH - 1, 32'h1234_5678);
    addrs[0] = 32'h0040_0002; addrs[1] = 32'h003F_FFFC;
    addrs[2] = 32'h0040_1000; addrs[3] = 32'h0040_0FFC;
    for (int i = 0; i < 4; i++) begin
      resp_ready = 1'b1;
      do_fetch(addrs[i], inst, e, lat, tmo);
      model(addrs[i], exp_e, exp_inst);
      n_vec++; if (tmo || lat !== W + 1) begin n_err++; $display("FAIL err_lat[%0d]: got %0d want %0d", i, lat, W + 1); end
      n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL err_flag[%0d]: got %b want %b", i, e, exp_e); end
      n_vec++; if (inst !== exp_inst) begin n_err++; $display("FAIL err_inst[%0d]: got %h want %h", i, inst, exp_inst); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, inst, exp_inst; logic e, exp_e; int lat, hold; bit tmo;
    for (int i = 0; i < 16; i++) load1($urandom_range(2, DEPTH - 2), $urandom);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = BASE + 32'(4 * loaded_q[$urandom_range(0, loaded_q.size() - 1)]);
        2:       a = BASE + 32'(4 * loaded_q[$urandom_range(0, loaded_q.size() - 1)]) + $urandom_range(1, 3);
        3:       a = $urandom_range(0, BASE - 1);
        default: a = BASE + 32'(DEPTH * 4) + $urandom_range(0, 32'h0FFF_FFFF);
      endcase
      model(a, exp_e, exp_inst);
      resp_ready = 1'b0;
      do_fetch(a, inst, e, lat, tmo);
      n_vec++; if (tmo || lat !== W + 1) begin n_err++; $display("FAIL rnd_lat: addr %h got %0d want %0d", a, lat, W + 1); end
      n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL rnd_err: addr %h got %b want %b", a, e, exp_e); end
      n_vec++; if (inst !== exp_inst) begin n_err++; $display("FAIL rnd_inst: addr %h got %h want %h", a, inst, exp_inst); end
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1 || resp_inst !== exp_inst) begin
        n_err++; $display("FAIL rnd_hold: valid %b inst %h want 1 %h", resp_valid, resp_inst, exp_inst);
      end
      resp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] inst; logic e; int lat; bit tmo;
    resp_ready = 1'b0;
    do_fetch(BASE, inst, e, lat, tmo);
    n_vec++; if (tmo || inst !== ref_mem[0]) begin n_err++; $display("FAIL bp_first: got %h want %h", inst, ref_mem[0]); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = BASE + 32'd4;
      ld_en = (k == 2); ld_idx = 10'd1; ld_data = 32'hDEAD_BEEF;
      #1;
      n_vec++; if (resp_valid !== 1'b1 || resp_inst !== ref_mem[0] || resp_err !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: valid %b inst %h err %b want 1 %h 0", k, resp_valid, resp_inst, resp_err, ref_mem[0]);
      end
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", k, req_ready); end
    end
    @(negedge clk);
    ld_en = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: valid %b ready %b want 0 1", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept: ready %b want 0", req_ready); end
    lat = 0;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL bp_lat2: got %0d want %0d", lat, W + 1); end
    n_vec++; if (resp_inst !== ref_mem[1]) begin n_err++; $display("FAIL bp_ld_ignored: got %h want %h", resp_inst, ref_mem[1]); end
    @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_single: valid %b want 0", resp_valid); end
  endtask

  task automatic test_ld_priority();
    logic [31:0] d; int lat;
    d = $urandom;
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 10'd7; ld_data = d;
    req_valid = 1'b1; req_addr = BASE + 32'd28;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL ldp_block: ready %b want 0", req_ready); end
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[7] = d; ref_ok[7] = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ldp_ready: ready %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL ldp_lat: got %0d want %0d", lat, W + 1); end
    n_vec++; if (resp_inst !== d) begin n_err++; $display("FAIL ldp_inst: got %h want %h", resp_inst, d); end
    @(negedge clk);
  endtask

  task automatic test_rst_wait();
    logic [31:0] inst; logic e; int lat; bit tmo, seen;
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rw_inwait: ready %b want 0", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rw_after: valid %b ready %b want 0 1", resp_valid, req_ready);
    end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    n_vec++; if (seen) begin n_err++; $display("FAIL rw_stale: got response want none"); end
    resp_ready = 1'b1;
    do_fetch(BASE, inst, e, lat, tmo);
    n_vec++; if (tmo || inst !== ref_mem[0] || e !== 1'b0) begin
      n_err++; $display("FAIL rw_mem: got %h %b want %h 0", inst, e, ref_mem[0]);
    end
    @(negedge clk);
  endtask

  // Accept-to-accept spacing: WAIT_CYCLES wait states + READ + RESP + IDLE.
  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int acc [4];
    int i, k;
    logic e; logic [31:0] x;
    for (int j = 0; j < 4; j++) begin
      addrs[j] = (j == 2) ? 32'h0040_0001 : BASE + 32'(4 * loaded_q[$urandom_range(0, loaded_q.size() - 1)]);
      model(addrs[j], e, x);
      exp_q.push_back(x);
    end
    resp_ready = 1'b1;
    i = 0; k = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addrs[0];
    while (k < 60 && got_q.size() < 4) begin
      if (resp_valid) got_q.push_back(resp_inst);
      if (req_ready && i < 4) begin acc[i] = k; i++; end
      @(negedge clk);
      k++;
      if (i < 4) req_addr = addrs[i]; else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    for (int j = 0; j < 4 && j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL b2b_inst[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
    end
    for (int j = 1; j < i; j++) begin
      n_vec++; if (acc[j] - acc[j-1] !== W + 3) begin
        n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", j, acc[j] - acc[j-1], W + 3);
      end
    end
  endtask

  task automatic test_wait0();
    logic [31:0] d; int lat;
    logic [31:0] addrs [2];
    logic exp_e [2];
    d = $urandom;
    addrs[0] = BASE;         exp_e[0] = 1'b0;
    addrs[1] = 32'h0040_1000; exp_e[1] = 1'b1;
    @(negedge clk);
    b_ld_en = 1'b1; b_ld_idx = 10'd0; b_ld_data = d;
    @(negedge clk);
    b_ld_en = 1'b0;
    for (int j = 0; j < 2; j++) begin
      b_req_valid = 1'b1; b_req_addr = addrs[j];
      #1;
      n_vec++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL w0_ready[%0d]: got %b want 1", j, b_req_ready); end
      @(negedge clk);
      b_req_valid = 1'b0;
      lat = 0;
      while (!b_resp_valid && lat < 40) begin @(negedge clk); lat++; end
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL w0_lat[%0d]: got %0d want 1", j, lat); end
      n_vec++; if (b_resp_inst !== (exp_e[j] ? 32'h0 : d)) begin
        n_err++; $display("FAIL w0_inst[%0d]: got %h want %h", j, b_resp_inst, exp_e[j] ? 32'h0 : d);
      end
      n_vec++; if (b_resp_err !== exp_e[j]) begin n_err++; $display("FAIL w0_err[%0d]: got %b want %b", j, b_resp_err, exp_e[j]); end
      @(negedge clk);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_data = 32'h0;
    b_req_valid = 1'b0; b_req_addr = 32'h0; b_resp_ready = 1'b1;
    b_ld_en = 1'b0; b_ld_idx = '0; b_ld_data = 32'h0;
    for (int j = 0; j < DEPTH; j++) begin ref_mem[j] = 32'h0; ref_ok[j] = 1'b0; end
    test_reset();
    test_basic();
    test_errors();
    test_random();
    test_backpressure();
    test_ld_priority();
    test_rst_wait();
    test_back_to_back();
    test_wait0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
